// File: rtl/stage10_pair_aligner_pkg.sv
// Shared FFT constants: sample format and per-stage butterfly span/address widths,
// so the twiddle provider and the pair aligner of a stage take them from one place.
package stage10_pair_aligner_pkg;

   localparam int FFT_POINTS = 32'sd8192;
   localparam int FFT_STAGES = 32'sd13;
   localparam int FLOAT_LEN  = 32'sd32;
   localparam int CPLX_LEN   = 32'sd2 * FLOAT_LEN;

   // Butterfly distance of a 1-based stage number; stage s pairs samples 2**(s-1) apart.
   function automatic int stage_span(input int stage);
      return 32'sd1 <<< (stage - 32'sd1);
   endfunction

   localparam int STAGE10_SPAN     = stage_span(32'sd10);
   localparam int STAGE10_ADDR_LEN = $clog2(STAGE10_SPAN);

endpackage

// File: rtl/stage_delay_ram.sv
// Single-port delay memory: synchronous read and write enable, no reset on the array,
// so it maps onto block RAM. Only the read register is cleared by reset.
module stage_delay_ram #(
   parameter int DEPTH    = 32'sd512,
   parameter int ADDR_LEN = 32'sd9,
   parameter int WIDTH    = 32'sd64
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_en,
   input  logic                i_we,
   input  logic [ADDR_LEN-1:0] i_addr,
   input  logic [WIDTH-1:0]    i_wdata,
   output logic [WIDTH-1:0]    o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Write port; the array keeps its contents through reset.
   always_ff @(posedge i_clk) begin
      if (i_en && i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Read register; holds its value on cycles without a read.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_en && !i_we) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/stage10_pair_aligner.sv
// Stage-10 pair aligner: buffers the first half of each 2*span block and emits
// (x1, x2) operand pairs span samples apart, with tf_en keeping the twiddle provider in step.
module stage10_pair_aligner
   import stage10_pair_aligner_pkg::*;
#(
   parameter int float_len     = FLOAT_LEN,
   parameter int span          = STAGE10_SPAN,
   parameter int span_addr_len = STAGE10_ADDR_LEN
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2*float_len-1:0] in_data,
   input  logic                   in_valid,
   output logic                   tf_en,
   output logic [2*float_len-1:0] out_x1,
   output logic [2*float_len-1:0] out_x2,
   output logic                   out_valid,
   output logic                   out_last
);

   localparam int CW = 32'sd2 * float_len;

   logic [span_addr_len:0]   r_cnt;
   logic [CW-1:0]            r_x2;
   logic                     r_valid;
   logic                     r_last;
   logic                     w_phase;
   logic [span_addr_len-1:0] w_idx;
   logic                     w_wr;
   logic                     w_rd;
   logic                     w_idx_last;

   // The counter MSB is the phase: low while filling memory, high while pairing.
   assign w_phase    = r_cnt[span_addr_len];
   assign w_idx      = r_cnt[span_addr_len-1:0];
   assign w_wr       = in_valid & ~w_phase;
   assign w_rd       = in_valid &  w_phase;
   assign w_idx_last = (w_idx == span_addr_len'(span - 32'sd1));

   // The twiddle provider registers this on the same edge that registers the pair.
   assign tf_en = w_rd;

   stage_delay_ram #(
      .DEPTH    (span),
      .ADDR_LEN (span_addr_len),
      .WIDTH    (CW)
   ) u_delay_ram (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_en    (in_valid),
      .i_we    (w_wr),
      .i_addr  (w_idx),
      .i_wdata (in_data),
      .o_rdata (out_x1)
   );

   // Sample counter and pair output registers; the counter wraps naturally at 2*span.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_x2    <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_valid <= w_rd;
         r_last  <= w_rd & w_idx_last;
         if (in_valid) begin
            r_cnt <= r_cnt + {{span_addr_len{1'b0}}, 1'b1};
         end
         if (w_rd) begin
            r_x2 <= in_data;
         end
      end
   end

   assign out_x2    = r_x2;
   assign out_valid = r_valid;
   assign out_last  = r_last;

endmodule
